// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the CLK_DIV configuration controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam int DEF_RATIO_WIDTH  = 8;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_RESET_RATIO  = 2;

  // Counter must hold both DRAIN_CYCLES-1 (up to 14) and ratio-1.
  function automatic int cnt_width(input int ratio_width);
    return (ratio_width > 4) ? ratio_width : 4;
  endfunction

endpackage

// File: rtl/cyc_down_counter.sv
// Loadable down-counter that parks at zero; zero_o flags the terminal count.
module cyc_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequences divide-ratio changes for CLK_DIV as drain -> load -> settle so the
// divider never sees its ratio change while enabled.
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH  = DEF_RATIO_WIDTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int RESET_RATIO  = DEF_RESET_RATIO
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_cfg_valid,
  input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
  output logic                   o_cfg_ready,
  output logic                   o_cfg_done,
  output logic                   o_cfg_err,
  output logic                   o_busy,
  output logic                   o_clk_en,
  output logic [RATIO_WIDTH-1:0] o_divide_ratio
);

  localparam int CW = cnt_width(RATIO_WIDTH);

  state_e                 state_q, state_d;
  logic [RATIO_WIDTH-1:0] pend_q, pend_d;
  logic [RATIO_WIDTH-1:0] div_q, div_d;
  logic                   clk_en_q, clk_en_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   cnt_load;
  logic [CW-1:0]          cnt_load_val;
  logic                   cnt_zero;
  logic                   accept;

  assign o_cfg_ready = (state_q == IDLE) && !i_rst;
  assign accept      = i_cfg_valid && o_cfg_ready;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    div_d        = div_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_cfg_ratio == '0) begin
            err_d = 1'b1;
          end else if (i_cfg_ratio == div_q) begin
            done_d = 1'b1;
          end else begin
            state_d      = DRAIN;
            pend_d       = i_cfg_ratio;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_zero) state_d = LOAD;
      end
      LOAD: begin
        // Settle spans one full output period of the new ratio.
        div_d        = pend_q;
        cnt_load     = 1'b1;
        cnt_load_val = CW'(pend_q) - CW'(1);
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    clk_en_d = ((state_d == IDLE) || (state_d == SETTLE)) ? i_enable : 1'b0;
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      div_q    <= RATIO_WIDTH'(RESET_RATIO);
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      div_q    <= div_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  cyc_down_counter #(
    .W (CW)
  ) u_cnt (
    .clk_i      (i_ref_clk),
    .rst_i      (i_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  assign o_cfg_done     = done_q;
  assign o_cfg_err      = err_q;
  assign o_busy         = (state_q != IDLE);
  assign o_clk_en       = clk_en_q;
  assign o_divide_ratio = div_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl; pulses are checked against a queue of
// expected completion/reject events, per-cycle levels are checked inline.
module tb_clk_div_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_ratio;
  logic       cfg_ready, cfg_done, cfg_err, busy, clk_en;
  logic [7:0] div_ratio;

  clk_div_cfg_ctrl dut (
    .i_ref_clk      (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_cfg_valid    (cfg_valid),
    .i_cfg_ratio    (cfg_ratio),
    .o_cfg_ready    (cfg_ready),
    .o_cfg_done     (cfg_done),
    .o_cfg_err      (cfg_err),
    .o_busy         (busy),
    .o_clk_en       (clk_en),
    .o_divide_ratio (div_ratio)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit         is_err;
    int         at;
    logic [7:0] ratio;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
      check("done_err_excl", {31'd0, cfg_done & cfg_err}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d done=%0b err=%0b", cyc, cfg_done, cfg_err);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", {31'd0, cfg_err}, {31'd0, mon_e.is_err});
        check("pulse_cycle", cyc, mon_e.at);
        check("pulse_ratio", {24'd0, div_ratio}, {24'd0, mon_e.ratio});
      end
    end
  end

  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // kind: 0 = no pulse expected, 1 = done, 2 = err. Returns acceptance cycle T.
  task automatic request(input logic [7:0] r, input int kind, input int delay,
                         input logic [7:0] exp_ratio, output int t);
    exp_t e;
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_ratio = r;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_timeout ratio=%0d got=not_ready want=ready", r);
    end else if (kind != 0) begin
      e.is_err = (kind == 2);
      e.at     = t + delay;
      e.ratio  = exp_ratio;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t5;
    rst       = 1'b1;
    en        = 1'b1;
    cfg_valid = 1'b0;
    cfg_ratio = 8'd0;

    // 1: reset then idle
    repeat (3) begin
      @(negedge clk);
      check("rst_ratio", {24'd0, div_ratio}, 32'd2);
      check("rst_clk_en", {31'd0, clk_en}, 32'd0);
      check("rst_ready", {31'd0, cfg_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("rel_ready", {31'd0, cfg_ready}, 32'd1);
    check("rel_clk_en0", {31'd0, clk_en}, 32'd0);
    @(negedge clk);
    check("rel_clk_en1", {31'd0, clk_en}, 32'd1);
    check("rel_ratio", {24'd0, div_ratio}, 32'd2);

    // 2 + 4a: 2->3 with a ratio-5 request held throughout the sequence
    request(8'd3, 1, 9, 8'd3, t);
    fork
      request(8'd5, 1, 11, 8'd5, t5);
      begin
        for (int k = 1; k <= 8; k++) begin
          at_cyc(t + k);
          check("seq_busy", {31'd0, busy}, 32'd1);
          check("seq_ready", {31'd0, cfg_ready}, 32'd0);
          if (k <= 5) begin
            check("drain_clk_en", {31'd0, clk_en}, 32'd0);
          end else begin
            check("settle_clk_en", {31'd0, clk_en}, 32'd1);
            check("settle_ratio", {24'd0, div_ratio}, 32'd3);
          end
        end
      end
    join
    check("b2b_accept_cyc", t5, t + 9);
    at_cyc(t5 + 11);
    check("r5_busy", {31'd0, busy}, 32'd0);

    request(8'd3, 1, 9, 8'd3, t);
    at_cyc(t + 9);

    // 3: reject and no-op
    request(8'd0, 2, 1, 8'd3, t);
    at_cyc(t + 1);
    check("rej_clk_en", {31'd0, clk_en}, 32'd1);
    check("rej_ratio", {24'd0, div_ratio}, 32'd3);
    check("rej_busy", {31'd0, busy}, 32'd0);
    request(8'd3, 1, 1, 8'd3, t);
    at_cyc(t + 1);
    check("noop_clk_en1", {31'd0, clk_en}, 32'd1);
    at_cyc(t + 2);
    check("noop_clk_en2", {31'd0, clk_en}, 32'd1);
    check("noop_busy", {31'd0, busy}, 32'd0);

    // 4b: 3->4, then 4->1 bypass
    request(8'd4, 1, 10, 8'd4, t);
    at_cyc(t + 10);
    request(8'd1, 1, 7, 8'd1, t);
    at_cyc(t + 6);
    check("byp_settle_busy", {31'd0, busy}, 32'd1);
    check("byp_settle_ratio", {24'd0, div_ratio}, 32'd1);
    at_cyc(t + 7);
    check("byp_idle_busy", {31'd0, busy}, 32'd0);

    // 5: reset mid-DRAIN during 2->5
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst2_ratio", {24'd0, div_ratio}, 32'd2);
    request(8'd5, 0, 0, 8'd0, t);
    at_cyc(t + 2);
    check("mid_drain_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_cyc", cyc, t + 4);
    check("abort_ratio", {24'd0, div_ratio}, 32'd2);
    check("abort_clk_en", {31'd0, clk_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, cfg_done}, 32'd0);
    end

    // 6: enable low through a 2->4 change
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("en0_idle", {31'd0, clk_en}, 32'd0);
    request(8'd4, 1, 10, 8'd4, t);
    for (int k = 1; k <= 10; k++) begin
      at_cyc(t + k);
      check("en0_clk_en", {31'd0, clk_en}, 32'd0);
    end
    @(posedge clk); #1; en = 1'b1;
    @(negedge clk);
    check("en_rise_lat0", {31'd0, clk_en}, 32'd0);
    @(negedge clk);
    check("en_rise_lat1", {31'd0, clk_en}, 32'd1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
Sequencing controller for the CLK_DIV clock divider. It accepts divide-ratio change requests over a valid/ready handshake and drives CLK_DIV's i_clk_en and i_divide_ratio.
- Each change runs as a safe gate/drain → load → settle sequence, so the generated clock never sees a ratio change while enabled.
- It sits in the ref-clock domain beside CLK_DIV and is the only driver of the divider's enable and ratio inputs.

Parameters:
- RATIO_WIDTH, 8: width of the divide ratio.
- DRAIN_CYCLES, 4: ref-clock cycles o_clk_en is held low before the ratio is loaded (range 1..15).
- RESET_RATIO, 2: o_divide_ratio value after reset (must be ≥1).

Ports:
- i_ref_clk, input, 1: reference clock; all logic on its rising edge.
- i_rst, input, 1: synchronous, active-high reset.
- i_enable, input, 1: master enable requested by software.
- i_cfg_valid, input, 1: ratio change request.
- i_cfg_ratio, input, RATIO_WIDTH: requested divide ratio.
- o_cfg_ready, output, 1: controller can accept a request.
- o_cfg_done, output, 1: one-cycle pulse when a change completes.
- o_cfg_err, output, 1: one-cycle pulse when a request is rejected.
- o_busy, output, 1: sequence in progress (state ≠ IDLE).
- o_clk_en, output, 1: to CLK_DIV i_clk_en.
- o_divide_ratio, output, RATIO_WIDTH: to CLK_DIV i_divide_ratio.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE, o_divide_ratio=RESET_RATIO, o_clk_en=0.
  - o_cfg_done=0, o_cfg_err=0, o_busy=0, o_cfg_ready=0 while i_rst is high.
  - Reset mid-sequence aborts the sequence; the pending ratio is discarded.
- o_cfg_ready=1 iff state==IDLE and not in reset. A request is accepted on a cycle T where i_cfg_valid & o_cfg_ready.
  - Valid while busy is ignored; the requester holds valid/ratio until ready.
  - i_cfg_ratio is captured only at acceptance.
- All outputs are registered. o_clk_en = i_enable registered when the next state is IDLE or SETTLE, else 0.
- States: IDLE, DRAIN, LOAD, SETTLE.
- Acceptance at T, classified on i_cfg_ratio:
  - ratio==0: reject. o_cfg_err=1 at T+1; state stays IDLE; o_clk_en and o_divide_ratio are unchanged.
  - ratio==o_divide_ratio: no-op. o_cfg_done=1 at T+1; stays IDLE; no enable drop.
  - Otherwise: go to DRAIN.
- DRAIN:
  - o_clk_en=0 from T+1.
  - Lasts DRAIN_CYCLES cycles (down-counter loaded with DRAIN_CYCLES-1), then LOAD.
- LOAD:
  - One cycle; o_clk_en=0.
  - o_divide_ratio takes the captured ratio at the end of LOAD, visible from T+DRAIN_CYCLES+2.
- SETTLE:
  - o_clk_en follows i_enable (registered).
  - Lasts exactly captured-ratio cycles (one full output period, counter loaded with ratio-1), then IDLE.
  - The settle count runs regardless of i_enable.
  - Ratio 1 (bypass) gives a 1-cycle settle.
- Completion:
  - o_cfg_done=1 and o_cfg_ready=1 in the first IDLE cycle, T+DRAIN_CYCLES+2+ratio.
  - A new request may be accepted in that same cycle.
- In IDLE, i_enable toggles propagate to o_clk_en with 1-cycle latency.
- o_busy=1 in DRAIN, LOAD and SETTLE.
- Counter width: max(RATIO_WIDTH, 4) bits; no wrap, since the counter is reloaded on every state entry.
- o_cfg_done and o_cfg_err are never high together.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, DRAIN, LOAD, SETTLE}.
  - RATIO_WIDTH, RESET_RATIO, DRAIN_CYCLES default constants.
- One sub-module, cyc_down_counter:
  - Loadable down-counter with a zero flag.
  - Shared by DRAIN and SETTLE; load value muxed by the FSM.
- The FSM and the output registers live in clk_div_cfg_ctrl.

Test Plan:
1. Reset then idle: i_rst high 3 cycles, i_enable=1 → o_divide_ratio=2 and o_clk_en=0 during reset; o_clk_en=1 one cycle after reset release; o_cfg_ready=1.
2. Change 2→3, request accepted at T (DRAIN_CYCLES=4):
   - o_clk_en=0 for T+1..T+5.
   - o_divide_ratio=3 and o_clk_en=1 from T+6.
   - o_busy=1 for T+1..T+8.
   - o_cfg_done pulse at T+9.
3. Reject and no-op:
   - ratio 0 → o_cfg_err pulse at T+1; ratio stays 3; o_clk_en stays 1.
   - ratio 3 → o_cfg_done at T+1 with no o_clk_en drop.
4. Back-to-back and busy:
   - Hold valid with ratio 5 during the test-2 sequence → accepted only at T+9.
   - Then ratio 4→1 (bypass): done 7 cycles after acceptance; o_divide_ratio=1.
5. Reset mid-DRAIN (ratio 2→5, i_rst at T+3) → next cycle o_divide_ratio=2, o_clk_en=0, o_busy=0, no o_cfg_done.
6. i_enable=0 throughout a 2→4 change → o_clk_en stays 0; o_cfg_done still at T+10. Raising i_enable afterwards sets o_clk_en one cycle later.
